// File: rtl/reduceron_run_ctrl.sv
// Run controller for a single Reduceron core: holds the core in reset, releases it,
// watches for completion or watchdog expiry, captures the outcome and hands it to a
// host-side consumer over a valid/ready handshake.
module reduceron_run_ctrl #(
  parameter int unsigned RST_CYCLES = 4,
  parameter int unsigned TIMEOUT    = 1000000,
  parameter int unsigned CYC_W      = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  output logic             busy,
  output logic             core_reset,
  input  logic [17:0]      core_result,
  input  logic [6:0]       core_state,
  input  logic [14:0]      core_heap,
  input  logic             core_finish,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [17:0]      res_value,
  output logic [6:0]       res_state,
  output logic [14:0]      res_heap,
  output logic [CYC_W-1:0] res_cycles,
  output logic             res_timeout
);

  typedef enum logic [1:0] {StIdle, StHold, StRun, StDone} state_e;

  localparam logic [31:0]      HoldLoad   = 32'(RST_CYCLES);
  localparam logic [CYC_W-1:0] TimeoutCnt = CYC_W'(TIMEOUT);
  localparam logic [CYC_W-1:0] CntOne     = {{(CYC_W-1){1'b0}}, 1'b1};
  localparam bit               WdogEn     = (TIMEOUT != 0);

  state_e           state_q, state_d;
  logic [31:0]      hold_q, hold_d;
  logic [CYC_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             capture, cap_timeout;

  logic             busy_q, core_reset_q, res_valid_q, res_timeout_q;
  logic [17:0]      res_value_q;
  logic [6:0]       res_state_q;
  logic [14:0]      res_heap_q;
  logic [CYC_W-1:0] res_cycles_q;

  // Count of the current RUN cycle; sticks at all-ones instead of wrapping.
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CntOne;

  // Next-state, hold/cycle counter updates and capture strobe.
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    cnt_d       = cnt_q;
    capture     = 1'b0;
    cap_timeout = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StHold;
          hold_d  = HoldLoad;
        end
      end
      StHold: begin
        hold_d = hold_q - 32'd1;
        if (hold_q <= 32'd1) begin
          state_d = StRun;
          cnt_d   = '0;
        end
      end
      StRun: begin
        cnt_d = cnt_inc;
        // Finish takes priority over a watchdog expiry in the same cycle.
        if (core_finish) begin
          capture = 1'b1;
          state_d = StDone;
        end else if (WdogEn && (cnt_inc == TimeoutCnt)) begin
          capture     = 1'b1;
          cap_timeout = 1'b1;
          state_d     = StDone;
        end
      end
      StDone: begin
        if (res_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM state and counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      hold_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
    end
  end

  // Registered status flags and captured outcome; values persist until the next capture.
  always_ff @(posedge clock) begin
    if (reset) begin
      busy_q        <= 1'b0;
      core_reset_q  <= 1'b1;
      res_valid_q   <= 1'b0;
      res_value_q   <= '0;
      res_state_q   <= '0;
      res_heap_q    <= '0;
      res_cycles_q  <= '0;
      res_timeout_q <= 1'b0;
    end else begin
      busy_q       <= (state_d != StIdle);
      core_reset_q <= (state_d != StRun);
      res_valid_q  <= (state_d == StDone);
      if (capture) begin
        res_value_q   <= core_result;
        res_state_q   <= core_state;
        res_heap_q    <= core_heap;
        res_cycles_q  <= cap_timeout ? TimeoutCnt : cnt_inc;
        res_timeout_q <= cap_timeout;
      end
    end
  end

  assign busy        = busy_q;
  assign core_reset  = core_reset_q;
  assign res_valid   = res_valid_q;
  assign res_value   = res_value_q;
  assign res_state   = res_state_q;
  assign res_heap    = res_heap_q;
  assign res_cycles  = res_cycles_q;
  assign res_timeout = res_timeout_q;

endmodule

// File: tb/tb_reduceron_run_ctrl.sv
// Bench for reduceron_run_ctrl: a watchdog-enabled instance driven through directed and
// randomized runs, plus a narrow-counter instance with the watchdog disabled.
module tb_reduceron_run_ctrl;

  localparam int unsigned RstCycles  = 4;
  localparam int unsigned Timeout    = 20;
  localparam int unsigned SRstCycles = 2;

  logic        clock = 1'b0;
  logic        reset, start, core_finish, res_ready;
  logic [17:0] core_result;
  logic [6:0]  core_state;
  logic [14:0] core_heap;
  logic        busy, core_reset, res_valid, res_timeout;
  logic [17:0] res_value;
  logic [6:0]  res_state;
  logic [14:0] res_heap;
  logic [31:0] res_cycles;

  logic        s_start, s_finish, s_ready;
  logic        s_busy, s_core_reset, s_valid, s_timeout;
  logic [17:0] s_value;
  logic [6:0]  s_state;
  logic [14:0] s_heap;
  logic [3:0]  s_cycles;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  reduceron_run_ctrl #(.RST_CYCLES(RstCycles), .TIMEOUT(Timeout), .CYC_W(32)) dut (
    .clock(clock), .reset(reset), .start(start), .busy(busy), .core_reset(core_reset),
    .core_result(core_result), .core_state(core_state), .core_heap(core_heap),
    .core_finish(core_finish), .res_valid(res_valid), .res_ready(res_ready),
    .res_value(res_value), .res_state(res_state), .res_heap(res_heap),
    .res_cycles(res_cycles), .res_timeout(res_timeout)
  );

  reduceron_run_ctrl #(.RST_CYCLES(SRstCycles), .TIMEOUT(0), .CYC_W(4)) u_sat (
    .clock(clock), .reset(reset), .start(s_start), .busy(s_busy), .core_reset(s_core_reset),
    .core_result(core_result), .core_state(core_state), .core_heap(core_heap),
    .core_finish(s_finish), .res_valid(s_valid), .res_ready(s_ready),
    .res_value(s_value), .res_state(s_state), .res_heap(s_heap),
    .res_cycles(s_cycles), .res_timeout(s_timeout)
  );

  // One complete run on the main instance. fin_at = RUN cycle on which the model core
  // raises finish (0 = never). Expected outcome follows from the run rules directly:
  // the run ends at min(fin_at, Timeout) and only a missing/late finish sets timeout.
  task automatic do_run(input string tag, input int fin_at, input int rdy_wait,
                        input bit noisy, input bit fixed);
    int          run_len;
    bit          exp_to;
    logic [17:0] er;
    logic [6:0]  es;
    logic [14:0] eh;
    exp_to  = (fin_at == 0) || (fin_at > int'(Timeout));
    run_len = exp_to ? int'(Timeout) : fin_at;
    er = '0; es = '0; eh = '0;
    start = 1'b1; core_finish = 1'b0; res_ready = 1'b0;
    @(negedge clock);
    for (int i = 0; i < int'(RstCycles); i++) begin
      n_checks++;
      if ({busy, core_reset, res_valid} !== 3'b110) begin
        n_fail++;
        $display("FAIL %s hold[%0d]: busy/core_reset/res_valid=%b want 110", tag, i,
                 {busy, core_reset, res_valid});
      end
      start       = noisy ? 1'($urandom) : 1'b0;
      core_finish = noisy ? 1'($urandom) : 1'b0;
      @(negedge clock);
    end
    for (int c = 1; c <= run_len; c++) begin
      n_checks++;
      if ({busy, core_reset, res_valid} !== 3'b100) begin
        n_fail++;
        $display("FAIL %s run[%0d]: busy/core_reset/res_valid=%b want 100", tag, c,
                 {busy, core_reset, res_valid});
      end
      core_result = 18'($urandom);
      core_state  = 7'($urandom);
      core_heap   = 15'($urandom);
      if (fixed && c == run_len) begin
        core_result = 18'h2A5A5; core_state = 7'h55; core_heap = 15'h1234;
      end
      core_finish = (c == fin_at);
      start       = noisy ? 1'($urandom) : 1'b0;
      if (c == run_len) begin
        er = core_result; es = core_state; eh = core_heap;
      end
      @(negedge clock);
    end
    for (int w = 0; w <= rdy_wait; w++) begin
      n_checks++;
      if ({busy, core_reset, res_valid} !== 3'b111) begin
        n_fail++;
        $display("FAIL %s done[%0d]: busy/core_reset/res_valid=%b want 111", tag, w,
                 {busy, core_reset, res_valid});
      end
      n_checks++;
      if ({res_value, res_state, res_heap, res_cycles, res_timeout} !==
          {er, es, eh, 32'(run_len), exp_to}) begin
        n_fail++;
        $display("FAIL %s outcome[%0d]: got v=%h s=%h h=%h c=%0d t=%b want v=%h s=%h h=%h c=%0d t=%b",
                 tag, w, res_value, res_state, res_heap, res_cycles, res_timeout,
                 er, es, eh, run_len, exp_to);
      end
      res_ready   = (w == rdy_wait);
      start       = noisy ? 1'($urandom) : 1'b0;
      core_finish = noisy ? 1'($urandom) : 1'b0;
      core_result = 18'($urandom);
      @(negedge clock);
    end
    res_ready   = 1'b0;
    start       = 1'b0;
    core_finish = noisy ? 1'($urandom) : 1'b0;
    n_checks++;
    if ({busy, core_reset, res_valid} !== 3'b010) begin
      n_fail++;
      $display("FAIL %s accept: busy/core_reset/res_valid=%b want 010", tag,
               {busy, core_reset, res_valid});
    end
    @(negedge clock);
    core_finish = 1'b0;
    n_checks++;
    if ({busy, res_valid, res_value, res_state, res_heap, res_cycles, res_timeout} !==
        {2'b00, er, es, eh, 32'(run_len), exp_to}) begin
      n_fail++;
      $display("FAIL %s after_accept: busy=%b valid=%b v=%h c=%0d t=%b want 0 0 %h %0d %b",
               tag, busy, res_valid, res_value, res_cycles, res_timeout, er, run_len, exp_to);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    n_checks++;
    if ({busy, core_reset, res_valid, res_value, res_state, res_heap, res_cycles,
         res_timeout} !== {3'b010, 73'd0}) begin
      n_fail++;
      $display("FAIL reset_main: busy/core_reset/valid=%b v=%h c=%0d t=%b want 010 all zero",
               {busy, core_reset, res_valid}, res_value, res_cycles, res_timeout);
    end
    n_checks++;
    if ({s_busy, s_core_reset, s_valid, s_cycles, s_timeout} !== 8'b010_0000_0) begin
      n_fail++;
      $display("FAIL reset_sat: busy/core_reset/valid=%b c=%0d t=%b want 010 0 0",
               {s_busy, s_core_reset, s_valid}, s_cycles, s_timeout);
    end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_basic();
    do_run("basic", 10, 5, 1'b0, 1'b1);
  endtask

  task automatic test_timeout();
    do_run("wdog_never", 0, 1, 1'b0, 1'b0);
    do_run("wdog_fin_at_limit", int'(Timeout), 0, 1'b0, 1'b0);
    do_run("wdog_fin_late", int'(Timeout) + 3, 0, 1'b0, 1'b0);
  endtask

  task automatic test_ignored_inputs();
    for (int i = 0; i < 6; i++) begin
      core_finish = 1'($urandom);
      @(negedge clock);
      n_checks++;
      if ({busy, core_reset, res_valid} !== 3'b010) begin
        n_fail++;
        $display("FAIL idle_finish[%0d]: busy/core_reset/res_valid=%b want 010", i,
                 {busy, core_reset, res_valid});
      end
    end
    core_finish = 1'b0;
    do_run("noisy", 7, 2, 1'b1, 1'b0);
  endtask

  task automatic test_reset_midrun();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (int'(RstCycles) + 4) @(negedge clock);
    n_checks++;
    if (core_reset !== 1'b0) begin
      n_fail++;
      $display("FAIL midrun_running: core_reset=%b want 0", core_reset);
    end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    n_checks++;
    if ({busy, core_reset, res_valid, res_value, res_state, res_heap, res_cycles,
         res_timeout} !== {3'b010, 73'd0}) begin
      n_fail++;
      $display("FAIL midrun_reset: busy/core_reset/valid=%b v=%h c=%0d t=%b want 010 all zero",
               {busy, core_reset, res_valid}, res_value, res_cycles, res_timeout);
    end
    @(negedge clock);
    do_run("after_reset", 5, 0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 10; k++) begin
      do_run($sformatf("rand%0d", k), int'($urandom_range(0, Timeout + 5)),
             int'($urandom_range(0, 3)), 1'b1, 1'b0);
    end
  endtask

  // Watchdog disabled, 4-bit counter: reported cycles are min(finish cycle, 15).
  task automatic test_saturate();
    int          fins[2] = '{7, 20};
    logic [17:0] er;
    for (int k = 0; k < 2; k++) begin
      s_start = 1'b1;
      @(negedge clock);
      s_start = 1'b0;
      repeat (SRstCycles) @(negedge clock);
      n_checks++;
      if ({s_busy, s_core_reset} !== 2'b10) begin
        n_fail++;
        $display("FAIL sat%0d_run: busy/core_reset=%b want 10", k, {s_busy, s_core_reset});
      end
      er = '0;
      for (int c = 1; c <= fins[k]; c++) begin
        core_result = 18'($urandom);
        s_finish    = (c == fins[k]);
        if (c == fins[k]) er = core_result;
        @(negedge clock);
      end
      s_finish = 1'b0;
      n_checks++;
      if ({s_valid, s_timeout, s_cycles, s_value} !==
          {2'b10, 4'((fins[k] > 15) ? 15 : fins[k]), er}) begin
        n_fail++;
        $display("FAIL sat%0d_outcome: valid=%b t=%b c=%0d v=%h want 1 0 %0d %h", k, s_valid,
                 s_timeout, s_cycles, s_value, (fins[k] > 15) ? 15 : fins[k], er);
      end
      s_ready = 1'b1;
      @(negedge clock);
      s_ready = 1'b0;
      @(negedge clock);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; core_finish = 1'b0; res_ready = 1'b0;
    core_result = '0; core_state = '0; core_heap = '0;
    s_start = 1'b0; s_finish = 1'b0; s_ready = 1'b0;
    test_reset();
    test_basic();
    test_timeout();
    test_ignored_inputs();
    test_reset_midrun();
    test_random();
    test_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
